exmemory_ctrl: RTL and testbench

Handshaked, parametrised successor to the processor's combinational memory decoder. Accepts one load/store request at a time over valid/ready and decodes the top 4 address bits into four regions: ROM, internal RAM, I/O, and unmapped. Each region has its own programmable wait states. Supports byte, halfword and word loads (sign- or zero-extended) and byte-lane stores, and flags misaligned, illegal and timed-out accesses as errors. Sits between the multicycle controller and the ROM / I/O devices.

---
 rtl/exmemory_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_exmemory_ctrl.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/exmemory_ctrl.sv
// Handshaked load/store controller: decodes ROM / internal RAM / I/O regions,
// applies per-region wait states, lane steering, load extension and error flagging.
module exmemory_ctrl #(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int RAM_AW     = 10,
    parameter int ROM_WAIT   = 0,
    parameter int RAM_WAIT   = 1,
    parameter int IO_TIMEOUT = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [2:0]            req_mode,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [WIDTH-1:0]      req_wdata,
    output logic                  resp_valid,
    output logic [WIDTH-1:0]      resp_rdata,
    output logic                  resp_err,
    output logic [RAM_AW-1:0]     rom_addr,
    input  logic [WIDTH-1:0]      rom_data,
    output logic                  io_valid,
    output logic                  io_write,
    output logic [ADDR_WIDTH-1:0] io_addr,
    output logic [WIDTH-1:0]      io_wdata,
    output logic [3:0]            io_be,
    input  logic                  io_ready,
    input  logic [WIDTH-1:0]      io_rdata
);

    localparam int WAIT_MAX = (ROM_WAIT > RAM_WAIT) ? ROM_WAIT : RAM_WAIT;
    localparam int CNT_MAX  = (WAIT_MAX > IO_TIMEOUT) ? WAIT_MAX : IO_TIMEOUT;
    localparam int CNT_W    = $clog2(CNT_MAX + 1);

    localparam logic [2:0] M_WORD = 3'b000;
    localparam logic [2:0] M_BS   = 3'b001;
    localparam logic [2:0] M_BU   = 3'b010;
    localparam logic [2:0] M_HS   = 3'b011;
    localparam logic [2:0] M_HU   = 3'b100;

    localparam logic [3:0] REG_ROM = 4'h0;
    localparam logic [3:0] REG_RAM = 4'h1;
    localparam logic [3:0] REG_IO  = 4'hF;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_IO, S_RESP} state_t;

    state_t                  r_state, w_next;
    logic                    r_write;
    logic [2:0]              r_mode;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [WIDTH-1:0]        r_wdata;
    logic [CNT_W-1:0]        r_cnt;
    logic [WIDTH-1:0]        r_rdata;
    logic                    r_err;
    logic [WIDTH-1:0]        r_mem [2**RAM_AW];

    logic                    w_accept;
    logic [3:0]              w_req_region;
    logic                    w_illegal;
    logic [CNT_W-1:0]        w_init_cnt;
    logic [3:0]              w_region;
    logic [RAM_AW-1:0]       w_index;
    logic                    w_access;
    logic                    w_io_last;
    logic [3:0]              w_be;
    logic [WIDTH-1:0]        w_lane_wdata;
    logic [WIDTH-1:0]        w_src;

    function automatic logic [31:0] f_extend(input logic [2:0] mode, input logic [1:0] off,
                                             input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(word >> {off, 3'b000});
        h = off[1] ? word[31:16] : word[15:0];
        case (mode)
            M_WORD:  f_extend = word;
            M_BS:    f_extend = {{24{b[7]}}, b};
            M_BU:    f_extend = {24'd0, b};
            M_HS:    f_extend = {{16{h[15]}}, h};
            M_HU:    f_extend = {16'd0, h};
            default: f_extend = '0;
        endcase
    endfunction

    function automatic logic [3:0] f_be(input logic [2:0] mode, input logic [1:0] off);
        case (mode)
            M_WORD:     f_be = 4'b1111;
            M_BS, M_BU: f_be = 4'b0001 << off;
            M_HS, M_HU: f_be = off[1] ? 4'b1100 : 4'b0011;
            default:    f_be = 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] f_lanes(input logic [2:0] mode, input logic [31:0] wdata);
        case (mode)
            M_BS, M_BU: f_lanes = {4{wdata[7:0]}};
            M_HS, M_HU: f_lanes = {2{wdata[15:0]}};
            default:    f_lanes = wdata;
        endcase
    endfunction

    function automatic logic f_illegal(input logic write, input logic [2:0] mode,
                                       input logic [1:0] lo, input logic [3:0] region);
        logic bad;
        bad = (mode > M_HU);
        if (mode == M_WORD && lo != 2'b00) bad = 1'b1;
        if ((mode == M_HS || mode == M_HU) && lo[0]) bad = 1'b1;
        if (write && region == REG_ROM) bad = 1'b1;
        if (region != REG_ROM && region != REG_RAM && region != REG_IO) bad = 1'b1;
        return bad;
    endfunction

    assign w_accept     = req_valid & req_ready;
    assign w_req_region = req_addr[ADDR_WIDTH-1 -: 4];
    assign w_illegal    = f_illegal(req_write, req_mode, req_addr[1:0], w_req_region);
    assign w_init_cnt   = (w_req_region == REG_ROM) ? CNT_W'(ROM_WAIT) :
                          (w_req_region == REG_RAM) ? CNT_W'(RAM_WAIT) : '0;

    assign w_region     = r_addr[ADDR_WIDTH-1 -: 4];
    assign w_index      = r_addr[RAM_AW+1:2];
    assign w_access     = (r_state == S_WAIT) && (r_cnt == '0);
    assign w_io_last    = (r_cnt == CNT_W'(IO_TIMEOUT - 1));
    assign w_be         = f_be(r_mode, r_addr[1:0]);
    assign w_lane_wdata = f_lanes(r_mode, r_wdata);
    assign w_src        = (w_region == REG_ROM) ? rom_data : r_mem[w_index];

    assign rom_addr = w_index;
    assign io_addr  = r_addr;
    assign io_wdata = w_lane_wdata;
    assign resp_rdata = r_rdata;
    assign resp_err   = r_err;

    always_ff @(posedge clk) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_accept) begin
                if (w_illegal)                  w_next = S_RESP;
                else if (w_req_region == REG_IO) w_next = S_IO;
                else                            w_next = S_WAIT;
            end
            S_WAIT: if (r_cnt == '0) w_next = S_RESP;
            S_IO:   if (io_ready || w_io_last) w_next = S_RESP;
            S_RESP: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready  = (r_state == S_IDLE) & reset;
        resp_valid = (r_state == S_RESP);
        io_valid   = (r_state == S_IO);
        io_write   = (r_state == S_IO) & r_write;
        io_be      = (r_state == S_IO) ? w_be : 4'b0000;
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_write <= req_write;
            r_mode  <= req_mode;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
        end
    end

    // The access edge is the only place RAM is written; a reset on that edge suppresses it.
    always_ff @(posedge clk) begin
        if (reset && w_access && r_write && w_region == REG_RAM) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) r_mem[w_index][8*b +: 8] <= w_lane_wdata[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cnt   <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (w_accept) begin
                    r_cnt   <= w_init_cnt;
                    r_rdata <= '0;
                    r_err   <= w_illegal;
                end
                S_WAIT: begin
                    if (r_cnt != '0)   r_cnt   <= r_cnt - CNT_W'(1);
                    else if (!r_write) r_rdata <= f_extend(r_mode, r_addr[1:0], w_src);
                end
                S_IO: begin
                    if (io_ready) begin
                        if (!r_write) r_rdata <= f_extend(r_mode, r_addr[1:0], io_rdata);
                        r_cnt <= '0;
                    end else if (w_io_last) begin
                        r_err <= 1'b1;
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_exmemory_ctrl.sv
// Directed bench for exmemory_ctrl: RAM/ROM/I/O accesses, lane handling, errors,
// timeout, reset abandonment and back-to-back handshakes.
module tb_exmemory_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [2:0]  req_mode = 3'b000;
    logic [15:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [9:0]  rom_addr;
    logic [31:0] rom_data;
    logic        io_valid;
    logic        io_write;
    logic [15:0] io_addr;
    logic [31:0] io_wdata;
    logic [3:0]  io_be;
    logic        io_ready = 1'b0;
    logic [31:0] io_rdata;

    int n_checks = 0;
    int n_pass = 0;

    int          io_delay = -1;
    logic [31:0] io_word = '0;
    int          io_cnt = 0;
    int          io_cycles = 0;
    logic [3:0]  io_be_s = '0;
    logic [15:0] io_addr_s = '0;
    logic [31:0] io_wdata_s = '0;
    logic        io_write_s = 1'b0;

    always #5 clk = ~clk;

    assign rom_data = 32'hC0DE0000 | {22'd0, rom_addr};
    assign io_rdata = io_word;

    exmemory_ctrl dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_mode(req_mode), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .io_valid(io_valid), .io_write(io_write), .io_addr(io_addr),
        .io_wdata(io_wdata), .io_be(io_be), .io_ready(io_ready), .io_rdata(io_rdata)
    );

    // I/O device model: raises io_ready in io_valid cycle (io_delay+1); never if io_delay < 0.
    initial begin
        forever begin
            @(negedge clk);
            if (io_valid) begin
                io_cnt = io_cnt + 1;
                if (io_cnt == 1) begin
                    io_be_s = io_be; io_addr_s = io_addr; io_wdata_s = io_wdata; io_write_s = io_write;
                end
                io_cycles = io_cnt;
                io_ready = (io_cnt == io_delay + 1);
            end else begin
                io_cnt = 0;
                io_ready = 1'b0;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    // lat = clock edges after the acceptance edge until resp_valid is first seen.
    task automatic do_req(input logic w, input logic [2:0] m, input logic [15:0] a,
                          input logic [31:0] wd, output logic [31:0] rd, output logic er,
                          output int lat);
        int t;
        rd = '0; er = 1'b0; lat = -1;
        req_write = w; req_mode = m; req_addr = a; req_wdata = wd; req_valid = 1'b1;
        t = 0;
        while (!req_ready && t < 50) begin
            @(posedge clk); #1; t++;
        end
        if (!req_ready) begin
            n_checks++;
            $display("FAIL req_ready_wait got 0 exp 1");
            req_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (resp_valid) begin
                lat = i; rd = resp_rdata; er = resp_err;
                break;
            end
            @(posedge clk); #1;
        end
        if (lat < 0) begin
            n_checks++;
            $display("FAIL resp_wait got none exp resp_valid");
        end
    endtask

    task automatic test_reset();
        logic [31:0] rd; logic er; int lat;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (req_ready !== 1'b0) $display("FAIL rst_req_ready got %b exp 0", req_ready); else n_pass++;
        n_checks++; if (resp_valid !== 1'b0) $display("FAIL rst_resp_valid got %b exp 0", resp_valid); else n_pass++;
        n_checks++; if (resp_rdata !== 32'h0) $display("FAIL rst_resp_rdata got %h exp 0", resp_rdata); else n_pass++;
        n_checks++; if (resp_err !== 1'b0) $display("FAIL rst_resp_err got %b exp 0", resp_err); else n_pass++;
        n_checks++; if (io_valid !== 1'b0) $display("FAIL rst_io_valid got %b exp 0", io_valid); else n_pass++;
        n_checks++; if (io_write !== 1'b0) $display("FAIL rst_io_write got %b exp 0", io_write); else n_pass++;
        n_checks++; if (io_be !== 4'b0000) $display("FAIL rst_io_be got %b exp 0000", io_be); else n_pass++;
        reset = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (req_ready !== 1'b1) $display("FAIL rst_release_ready got %b exp 1", req_ready); else n_pass++;

        do_req(1'b1, 3'b000, 16'h1010, 32'h11223344, rd, er, lat);
        @(posedge clk); #1;
        // Start a store that reset abandons exactly on its access edge.
        req_write = 1'b1; req_mode = 3'b000; req_addr = 16'h1010; req_wdata = 32'h55555555; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
            n_checks++; if (resp_valid !== 1'b0) $display("FAIL abort_resp_valid got %b exp 0", resp_valid); else n_pass++;
            n_checks++; if (req_ready !== 1'b0) $display("FAIL abort_req_ready got %b exp 0", req_ready); else n_pass++;
        end
        reset = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (req_ready !== 1'b1) $display("FAIL abort_release_ready got %b exp 1", req_ready); else n_pass++;
        n_checks++; if (resp_valid !== 1'b0) $display("FAIL abort_release_resp got %b exp 0", resp_valid); else n_pass++;
        do_req(1'b0, 3'b000, 16'h1010, 32'h0, rd, er, lat);
        n_checks++; if (rd !== 32'h11223344) $display("FAIL abort_word_kept got %h exp 11223344", rd); else n_pass++;
        n_checks++; if (er !== 1'b0) $display("FAIL abort_load_err got %b exp 0", er); else n_pass++;
    endtask

    task automatic test_word_rw();
        logic [31:0] rd; logic er; int lat;
        do_req(1'b1, 3'b000, 16'h1000, 32'hDEADBEEF, rd, er, lat);
        n_checks++; if (lat !== 2) $display("FAIL ram_store_lat got %0d exp 2", lat); else n_pass++;
        n_checks++; if (er !== 1'b0) $display("FAIL ram_store_err got %b exp 0", er); else n_pass++;
        n_checks++; if (rd !== 32'h0) $display("FAIL ram_store_rdata got %h exp 0", rd); else n_pass++;
        do_req(1'b0, 3'b000, 16'h1000, 32'h0, rd, er, lat);
        n_checks++; if (rd !== 32'hDEADBEEF) $display("FAIL ram_load_word got %h exp deadbeef", rd); else n_pass++;
        n_checks++; if (lat !== 2) $display("FAIL ram_load_lat got %0d exp 2", lat); else n_pass++;
        @(posedge clk); #1;
        n_checks++; if (resp_valid !== 1'b0) $display("FAIL resp_one_cycle got %b exp 0", resp_valid); else n_pass++;
        n_checks++; if (req_ready !== 1'b1) $display("FAIL idle_after_resp got %b exp 1", req_ready); else n_pass++;
    endtask

    task automatic test_byte_half();
        logic [31:0] rd; logic er; int lat;
        do_req(1'b1, 3'b010, 16'h1003, 32'h12345680, rd, er, lat);
        do_req(1'b0, 3'b001, 16'h1003, 32'h0, rd, er, lat);
        n_checks++; if (rd !== 32'hFFFFFF80) $display("FAIL byte_signed got %h exp ffffff80", rd); else n_pass++;
        do_req(1'b0, 3'b010, 16'h1003, 32'h0, rd, er, lat);
        n_checks++; if (rd !== 32'h00000080) $display("FAIL byte_unsigned got %h exp 00000080", rd); else n_pass++;
        do_req(1'b0, 3'b011, 16'h1002, 32'h0, rd, er, lat);
        n_checks++; if (rd !== 32'hFFFF80AD) $display("FAIL half_signed_hi got %h exp ffff80ad", rd); else n_pass++;
        do_req(1'b0, 3'b100, 16'h1000, 32'h0, rd, er, lat);
        n_checks++; if (rd !== 32'h0000BEEF) $display("FAIL half_unsigned_lo got %h exp 0000beef", rd); else n_pass++;
        do_req(1'b1, 3'b011, 16'h1000, 32'hCAFE1234, rd, er, lat);
        do_req(1'b0, 3'b000, 16'h1000, 32'h0, rd, er, lat);
        n_checks++; if (rd !== 32'h80AD1234) $display("FAIL half_store_merge got %h exp 80ad1234", rd); else n_pass++;
        do_req(1'b0, 3'b010, 16'h1001, 32'h0, rd, er, lat);
        n_checks++; if (rd !== 32'h00000012) $display("FAIL byte_lane1 got %h exp 00000012", rd); else n_pass++;
        do_req(1'b0, 3'b001, 16'h0007, 32'h0, rd, er, lat);
        n_checks++; if (rd !== 32'hFFFFFFC0) $display("FAIL rom_byte_signed got %h exp ffffffc0", rd); else n_pass++;
        n_checks++; if (lat !== 1) $display("FAIL rom_lat got %0d exp 1", lat); else n_pass++;
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic er; int lat;
        logic        w_tab [5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [2:0]  m_tab [5]  = '{3'b000, 3'b000, 3'b110, 3'b000, 3'b011};
        logic [15:0] a_tab [5]  = '{16'h1002, 16'h0004, 16'h1000, 16'h5000, 16'h1001};
        for (int i = 0; i < 5; i++) begin
            do_req(w_tab[i], m_tab[i], a_tab[i], 32'h0, rd, er, lat);
            n_checks++; if (er !== 1'b1) $display("FAIL err_flag_%0d got %b exp 1", i, er); else n_pass++;
            n_checks++; if (rd !== 32'h0) $display("FAIL err_rdata_%0d got %h exp 0", i, rd); else n_pass++;
            n_checks++; if (lat !== 0) $display("FAIL err_lat_%0d got %0d exp 0", i, lat); else n_pass++;
        end
        do_req(1'b0, 3'b000, 16'h1000, 32'h0, rd, er, lat);
        n_checks++; if (rd !== 32'h80AD1234) $display("FAIL err_ram_unchanged got %h exp 80ad1234", rd); else n_pass++;
    endtask

    task automatic test_io();
        logic [31:0] rd; logic er; int lat;
        io_word = 32'h7777ABCD; io_delay = 3; io_cycles = 0;
        do_req(1'b0, 3'b100, 16'hF010, 32'h0, rd, er, lat);
        n_checks++; if (rd !== 32'h0000ABCD) $display("FAIL io_half_u got %h exp 0000abcd", rd); else n_pass++;
        n_checks++; if (er !== 1'b0) $display("FAIL io_half_u_err got %b exp 0", er); else n_pass++;
        n_checks++; if (lat !== 4) $display("FAIL io_lat got %0d exp 4", lat); else n_pass++;
        n_checks++; if (io_be_s !== 4'b0011) $display("FAIL io_load_be got %b exp 0011", io_be_s); else n_pass++;
        n_checks++; if (io_addr_s !== 16'hF010) $display("FAIL io_addr got %h exp f010", io_addr_s); else n_pass++;
        n_checks++; if (io_write_s !== 1'b0) $display("FAIL io_load_write got %b exp 0", io_write_s); else n_pass++;

        io_word = 32'h8001ABCD; io_delay = 1;
        do_req(1'b0, 3'b011, 16'hF012, 32'h0, rd, er, lat);
        n_checks++; if (rd !== 32'hFFFF8001) $display("FAIL io_half_s got %h exp ffff8001", rd); else n_pass++;
        n_checks++; if (io_be_s !== 4'b1100) $display("FAIL io_half_hi_be got %b exp 1100", io_be_s); else n_pass++;
        n_checks++; if (lat !== 2) $display("FAIL io_lat2 got %0d exp 2", lat); else n_pass++;

        io_delay = 0;
        do_req(1'b1, 3'b001, 16'hF013, 32'h0000005A, rd, er, lat);
        n_checks++; if (io_be_s !== 4'b1000) $display("FAIL io_store_be got %b exp 1000", io_be_s); else n_pass++;
        n_checks++; if (io_wdata_s !== 32'h5A5A5A5A) $display("FAIL io_store_wdata got %h exp 5a5a5a5a", io_wdata_s); else n_pass++;
        n_checks++; if (io_write_s !== 1'b1) $display("FAIL io_store_write got %b exp 1", io_write_s); else n_pass++;
        n_checks++; if (rd !== 32'h0 || er !== 1'b0) $display("FAIL io_store_resp got %h/%b exp 0/0", rd, er); else n_pass++;
        n_checks++; if (lat !== 1) $display("FAIL io_store_lat got %0d exp 1", lat); else n_pass++;

        io_delay = -1; io_cycles = 0;
        do_req(1'b0, 3'b000, 16'hF000, 32'h0, rd, er, lat);
        n_checks++; if (er !== 1'b1) $display("FAIL io_timeout_err got %b exp 1", er); else n_pass++;
        n_checks++; if (rd !== 32'h0) $display("FAIL io_timeout_rdata got %h exp 0", rd); else n_pass++;
        n_checks++; if (lat !== 15) $display("FAIL io_timeout_lat got %0d exp 15", lat); else n_pass++;
        n_checks++; if (io_cycles !== 15) $display("FAIL io_timeout_cycles got %0d exp 15", io_cycles); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic exp_rdy [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic exp_rv  [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        @(posedge clk); #1;
        n_checks++; if (req_ready !== 1'b1) $display("FAIL b2b_start_ready got %b exp 1", req_ready); else n_pass++;
        req_write = 1'b0; req_mode = 3'b000; req_addr = 16'h0008; req_wdata = '0; req_valid = 1'b1;
        for (int e = 0; e < 6; e++) begin
            @(posedge clk); #1;
            if (e == 5) req_valid = 1'b0;
            n_checks++; if (req_ready !== exp_rdy[e]) $display("FAIL b2b_ready_%0d got %b exp %b", e, req_ready, exp_rdy[e]); else n_pass++;
            n_checks++; if (resp_valid !== exp_rv[e]) $display("FAIL b2b_resp_valid_%0d got %b exp %b", e, resp_valid, exp_rv[e]); else n_pass++;
            if (exp_rv[e]) begin
                n_checks++; if (resp_rdata !== 32'hC0DE0002) $display("FAIL b2b_rom_rdata_%0d got %h exp c0de0002", e, resp_rdata); else n_pass++;
                n_checks++; if (resp_err !== 1'b0) $display("FAIL b2b_rom_err_%0d got %b exp 0", e, resp_err); else n_pass++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_word_rw();
        test_byte_half();
        test_errors();
        test_io();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
